// File: rtl/sdc_sector_engine.sv
`default_nettype none
// ============================================================================
// Module   : sdc_sector_engine
// Purpose  : Bus-slave sequencer between the CPU data bus and the
//            sd_controller SPI engine. Holds a 512-byte sector buffer and a
//            small register window; runs single-block reads/writes and reports
//            completion through STATUS and a one-cycle irq pulse.
// Ports    : clk/reset            - system clock, async active-high reset
//            bus_*                - CPU slave port (1 KB window at BASE)
//            sd_rd/sd_wr/sd_*     - request/data handshake to sd_controller
//            irq                  - one-cycle pulse on completion or abort
// Revision : 1.0 - initial release
// ============================================================================
module sdc_sector_engine #(
  parameter logic [63:0] BASE    = 64'h0000_0000_0000_3000,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [63:0] bus_write_data,
  output logic [63:0] bus_read_data,
  output logic        bus_read_done,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic        sd_ready,
  output logic        irq
);

  localparam logic [9:0] C_OFF_ADDR   = 10'h200;
  localparam logic [9:0] C_OFF_CMD_RD = 10'h208;
  localparam logic [9:0] C_OFF_CMD_WR = 10'h210;
  localparam logic [9:0] C_OFF_STATUS = 10'h218;
  localparam logic [9:0] C_LAST_BYTE  = 10'd511;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_DATA = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  count_q, count_d;
  logic [23:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic        sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [31:0] sd_address_q, sd_address_d;
  logic [7:0]  sd_din_q, sd_din_d;
  logic        bya_prev_q, bya_prev_d, rfnb_prev_q, rfnb_prev_d, we_prev_q, we_prev_d;
  logic        rd_v1_q, rd_v1_d;
  logic [9:0]  rd_off1_q, rd_off1_d;
  logic [63:0] bus_read_data_q, bus_read_data_d;
  logic        bus_read_done_q, bus_read_done_d;

  // Sector buffer: one write port shared by CPU and engine (never active
  // together since CPU buffer writes are blocked while busy), two read ports.
  logic [7:0] sec_mem [0:511];
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] cpu_rd_q, eng_rd_q;

  logic        w_in_win, w_we_fire, w_cmd_rd, w_cmd_wr, w_busy, w_card_ready;
  logic        w_bya_rise, w_rfnb_rise, w_timed, w_byte_evt;
  logic [9:0]  w_off;
  logic [63:0] w_status;
  logic        w_unused_ok;

  assign w_in_win     = (bus_address[63:10] == BASE[63:10]);
  assign w_off        = bus_address[9:0];
  assign w_we_fire    = bus_write_enable && !we_prev_q && w_in_win;
  assign w_cmd_rd     = w_we_fire && (w_off == C_OFF_CMD_RD);
  assign w_cmd_wr     = w_we_fire && (w_off == C_OFF_CMD_WR);
  assign w_busy       = (state_q != S_IDLE);
  assign w_card_ready = sd_ready && !w_busy;
  assign w_bya_rise   = sd_byte_available && !bya_prev_q;
  assign w_rfnb_rise  = sd_ready_for_next_byte && !rfnb_prev_q;
  assign w_timed      = (state_q == S_RD_REQ) || (state_q == S_RD_DATA) ||
                        (state_q == S_WR_REQ) || (state_q == S_WR_DATA);
  assign w_byte_evt   = ((state_q == S_RD_DATA) && w_bya_rise) ||
                        ((state_q == S_WR_DATA) && w_rfnb_rise);
  assign w_status     = {50'd0, count_q, err_q, done_q, w_busy, w_card_ready};
  assign w_unused_ok  = &{1'b0, bus_write_data[63:32]};

  always_ff @(posedge clk) begin
    if (mem_we) sec_mem[mem_waddr] <= mem_wdata;
    cpu_rd_q <= sec_mem[bus_address[8:0]];
    // Continuous prefetch so sd_din already holds buffer[count] when the
    // controller raises its next-byte request.
    eng_rd_q <= sec_mem[count_q[8:0]];
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    addr_d          = addr_q;
    done_d          = done_q;
    err_d           = err_q;
    irq_d           = 1'b0;
    sd_rd_d         = sd_rd_q;
    sd_wr_d         = sd_wr_q;
    sd_address_d    = sd_address_q;
    sd_din_d        = sd_din_q;
    bya_prev_d      = sd_byte_available;
    rfnb_prev_d     = sd_ready_for_next_byte;
    we_prev_d       = bus_write_enable;
    mem_we          = 1'b0;
    mem_waddr       = count_q[8:0];
    mem_wdata       = sd_dout;

    // Read pipeline: stage 1 captures address/RAM, stage 2 drives the bus.
    rd_v1_d         = bus_read_enable && w_in_win;
    rd_off1_d       = w_off;
    bus_read_done_d = rd_v1_q && bus_read_enable;
    bus_read_data_d = bus_read_data_q;
    if (rd_v1_q) begin
      if (!rd_off1_q[9]) begin
        bus_read_data_d = {56'd0, cpu_rd_q};
      end else begin
        case (rd_off1_q)
          C_OFF_ADDR:   bus_read_data_d = {32'd0, addr_q};
          C_OFF_STATUS: bus_read_data_d = w_status;
          default:      bus_read_data_d = '0;
        endcase
      end
    end

    // CPU register/buffer writes
    if (w_we_fire) begin
      if (!w_off[9]) begin
        if (!w_busy) begin
          mem_we    = 1'b1;
          mem_waddr = w_off[8:0];
          mem_wdata = bus_write_data[7:0];
        end
      end else if (w_off == C_OFF_ADDR) begin
        if (w_busy) err_d = 1'b1;
        else        addr_d = bus_write_data[31:0];
      end
    end

    if (state_q == S_WR_REQ || state_q == S_WR_DATA) sd_din_d = eng_rd_q;

    case (state_q)
      S_IDLE: begin
        if (w_cmd_rd || w_cmd_wr) begin
          if (sd_ready) begin
            done_d       = 1'b0;
            err_d        = 1'b0;
            count_d      = '0;
            sd_address_d = addr_q;
            if (w_cmd_rd) begin
              sd_rd_d = 1'b1;
              state_d = S_RD_REQ;
            end else begin
              sd_wr_d = 1'b1;
              state_d = S_WR_REQ;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (!sd_ready) begin
          sd_rd_d = 1'b0;
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (w_bya_rise) begin
          mem_we  = 1'b1;
          count_d = count_q + 10'd1;
          if (count_q == C_LAST_BYTE) state_d = S_FINISH;
        end
      end
      S_WR_REQ: begin
        if (!sd_ready) begin
          sd_wr_d = 1'b0;
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_rfnb_rise) begin
          count_d = count_q + 10'd1;
          if (count_q == C_LAST_BYTE) state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (sd_ready) begin
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any command that is not accepted from IDLE is flagged.
    if ((w_cmd_rd || w_cmd_wr) && w_busy) err_d = 1'b1;

    // Watchdog on the data phases; overrides whatever the FSM decided.
    if (w_timed && (tmo_q == TIMEOUT - 24'd1)) begin
      sd_rd_d = 1'b0;
      sd_wr_d = 1'b0;
      err_d   = 1'b1;
      irq_d   = 1'b1;
      count_d = count_q;
      mem_we  = 1'b0;
      state_d = S_IDLE;
    end

    if (!w_timed || (state_d != state_q) || w_byte_evt) tmo_d = '0;
    else                                                tmo_d = tmo_q + 24'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      tmo_q           <= '0;
      addr_q          <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      irq_q           <= 1'b0;
      sd_rd_q         <= 1'b0;
      sd_wr_q         <= 1'b0;
      sd_address_q    <= '0;
      sd_din_q        <= '0;
      bya_prev_q      <= 1'b0;
      rfnb_prev_q     <= 1'b0;
      we_prev_q       <= 1'b0;
      rd_v1_q         <= 1'b0;
      rd_off1_q       <= '0;
      bus_read_data_q <= '0;
      bus_read_done_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      tmo_q           <= tmo_d;
      addr_q          <= addr_d;
      done_q          <= done_d;
      err_q           <= err_d;
      irq_q           <= irq_d;
      sd_rd_q         <= sd_rd_d;
      sd_wr_q         <= sd_wr_d;
      sd_address_q    <= sd_address_d;
      sd_din_q        <= sd_din_d;
      bya_prev_q      <= bya_prev_d;
      rfnb_prev_q     <= rfnb_prev_d;
      we_prev_q       <= we_prev_d;
      rd_v1_q         <= rd_v1_d;
      rd_off1_q       <= rd_off1_d;
      bus_read_data_q <= bus_read_data_d;
      bus_read_done_q <= bus_read_done_d;
    end
  end

  assign bus_read_data = bus_read_data_q;
  assign bus_read_done = bus_read_done_q;
  assign sd_rd         = sd_rd_q;
  assign sd_wr         = sd_wr_q;
  assign sd_address    = sd_address_q;
  assign sd_din        = sd_din_q;
  assign irq           = irq_q;

endmodule
`default_nettype wire

// File: doc/sdc_sector_engine.md
# sdc_sector_engine

Memory-mapped sequencer that sits between the CPU data bus and the `sd_controller` SPI engine. It holds a 512-byte sector buffer and a small register window. On a CPU command it drives a single-block read or write through `sd_controller`, streaming bytes between the card and the buffer, then reports completion through a status register. It replaces ad-hoc top-level SD sequencing with one bus slave that has fixed, testable handshakes.

## Interface
Parameters:
- `BASE` — 64'h0000_0000_0000_3000 — byte base address of the block's 1 KB window
- `TIMEOUT` — 24'd5_000_000 — cycles with no byte event in a data phase before the transfer is aborted

Ports:
- `clk` in 1 — system clock (CLOCK_50 domain)
- `reset` in 1 — asynchronous, active-high reset
- `bus_address` in 64 — CPU byte address
- `bus_read_enable` in 1 — CPU read strobe (level, held until done)
- `bus_write_enable` in 1 — CPU write strobe (single-cycle effect per assertion edge)
- `bus_write_data` in 64 — CPU write data
- `bus_read_data` out 64 — read data, valid when `bus_read_done`=1
- `bus_read_done` out 1 — read acknowledge
- `sd_rd` out 1 — block read request to sd_controller
- `sd_wr` out 1 — block write request to sd_controller
- `sd_address` out 32 — card block address
- `sd_din` out 8 — write byte to sd_controller
- `sd_dout` in 8 — read byte from sd_controller
- `sd_byte_available` in 1 — read byte valid (level)
- `sd_ready_for_next_byte` in 1 — write byte request (level)
- `sd_ready` in 1 — controller idle and initialised
- `irq` out 1 — one-cycle pulse on transfer completion or abort

## Operation
- Address map (offsets from BASE): 0x000–0x1FF buffer byte window; 0x200 ADDR (W/R, bits[31:0]); 0x208 CMD_READ (W, any data); 0x210 CMD_WRITE (W, any data); 0x218 STATUS (R).
- STATUS bits: [0] card_ready = sd_ready && state==IDLE; [1] busy; [2] done (sticky); [3] err (sticky); [13:4] byte count (0–512); others 0.
- Buffer: 512×8 synchronous RAM, one port for CPU, one for engine. CPU buffer reads return byte zero-extended to 64 bits.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, FINISH.
- IDLE: CMD_READ write with sd_ready=1 → clear done/err, count=0, go to RD_REQ. CMD_WRITE likewise → WR_REQ. Command while sd_ready=0 or state≠IDLE → ignored, err set.
- RD_REQ: sd_rd=1, sd_address=ADDR. Stay until sd_ready=0, then sd_rd=0 and go to RD_DATA.
- RD_DATA: each rising edge of sd_byte_available writes sd_dout to buffer[count], count+1. When count reaches 512, go to FINISH.
- WR_REQ/WR_DATA: symmetric. sd_wr is held until sd_ready=0. On each rising edge of sd_ready_for_next_byte, sd_din=buffer[count] is presented (prefetched so it is stable on the edge), count+1. At 512, go to FINISH.
- FINISH: wait for sd_ready=1, set done, pulse irq, return to IDLE.
- Timeout: in RD_REQ/RD_DATA/WR_REQ/WR_DATA, a counter resets on every byte event or state change. At TIMEOUT, drop sd_rd/sd_wr, set err, pulse irq, go to IDLE.
- CPU buffer writes are ignored while busy. CPU buffer reads while busy are allowed and return current contents.
- Engine buffer write and CPU buffer write in the same cycle cannot occur, because CPU writes are blocked while busy.
- Writes to ADDR while busy are ignored and set err.
- Accesses outside the window: no effect, bus_read_done stays 0.

## Timing
- Reset values: bus_read_data=0, bus_read_done=0, sd_rd=0, sd_wr=0, sd_address=0, sd_din=0, irq=0, ADDR=0, state=IDLE, count=0, done=0, err=0.
- Read latency: bus_read_done rises 2 cycles after bus_read_enable is first seen on an in-window address (address register, then RAM/register output). It stays high while bus_read_enable stays high and drops the cycle after enable falls.
- Write effect: registers and buffer update on the first cycle that bus_write_enable is high. Further cycles of the same assertion are ignored (edge-detected).
- sd_rd/sd_wr rise the cycle after the command write.
- Byte edges: sd_byte_available and sd_ready_for_next_byte are sampled with a 1-cycle delay register. The byte is captured on the cycle the edge is detected.
- irq: exactly 1 cycle, the cycle done or err is set.
- Reset asserted mid-transfer: all outputs return to reset values immediately. Buffer contents are undefined.

## Test plan
- Read: write ADDR=0x10, CMD_READ. The sd model drops sd_ready and then supplies bytes 0x00..0xFF,0x00..0xFF. Required: count=512, done=1, one irq pulse, and buffer offset 0x1FF reads back 0xFF.
- Write: fill buffer with offset[7:0]^0xA5, CMD_WRITE. Required: the model receives 512 bytes in order (first 0xA5, last 0x5A), then done=1.
- Busy rejection: CMD_READ during RD_DATA, and a buffer write during RD_DATA. Required: err=1, the transfer still completes with 512 bytes, and the buffer byte is not overwritten by the CPU.
- Not ready: sd_ready=0 with CMD_READ. Required: sd_rd stays 0, err=1, state=IDLE.
- Timeout: the model stops after 100 bytes with TIMEOUT=1000. Required: at 1000 idle cycles err=1, irq pulses, sd_rd=0, count=100.
- Reset mid-transfer at byte 37. Required: all outputs are 0, STATUS reads 0 (sd_ready=0), and a new read then completes normally.
